// File: rtl/quantser_seqctrl.sv
// Load/step sequencer for the MVU quantizer/serializer output shift register.
// Optional one-deep job queue enabled by defining QUANTSER_PEND_EN.
module quantser_seqctrl #(
  parameter int BWOUT    = 32,
  parameter int BWBWOUT  = $clog2(BWOUT),
  parameter int MAXBURST = 16,
  parameter int BWBURST  = $clog2(MAXBURST)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [BWBWOUT-1:0] bwout,
  input  logic [BWBWOUT-1:0] msbidx,
  input  logic [BWBURST-1:0] nwords,
  input  logic               start,
  input  logic               stall,
  output logic               ready,
  output logic               busy,
  output logic               load,
  output logic               step,
  output logic [BWBWOUT-1:0] bitpos,
  output logic [BWBURST-1:0] wordidx,
  output logic               last,
  output logic               done,
  output logic               ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [BWBWOUT-1:0] counter;
  logic [BWBWOUT-1:0] bw_l, msb_l;
  logic [BWBURST-1:0] nw_l;
  logic               accept, finish, adv_word, take_new;

`ifdef QUANTSER_PEND_EN
  logic               pend_v;
  logic [BWBWOUT-1:0] pbw_l, pmsb_l;
  logic [BWBURST-1:0] pnw_l;
  logic               take_pend, fill_pend;

  assign ready = (state == IDLE) | ~pend_v;
`else
  assign ready = (state == IDLE);
`endif

  assign busy   = (state != IDLE);
  assign accept = start & ready;

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    adv_word = 1'b0;
    take_new = 1'b0;
`ifdef QUANTSER_PEND_EN
    take_pend = 1'b0;
    fill_pend = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_n  = LOAD;
          take_new = 1'b1;
        end
      end
      LOAD: begin
        if (!stall && !clr) begin
          load = 1'b1;
          if (bw_l != '0)          state_n = SHIFT;
          else if (wordidx == nw_l) finish = 1'b1;
          else                     adv_word = 1'b1;
        end
      end
      SHIFT: begin
        if (!stall && !clr) begin
          step = 1'b1;
          if (counter == BWBWOUT'(1)) begin
            if (wordidx == nw_l) finish = 1'b1;
            else begin
              adv_word = 1'b1;
              state_n  = LOAD;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A finishing job chains straight into the queued or just-accepted job.
    if (finish) begin
      state_n = IDLE;
`ifdef QUANTSER_PEND_EN
      if (pend_v) begin
        state_n   = LOAD;
        take_pend = 1'b1;
      end else if (accept) begin
        state_n  = LOAD;
        take_new = 1'b1;
      end
`endif
    end
`ifdef QUANTSER_PEND_EN
    else if (accept && state != IDLE) begin
      fill_pend = 1'b1;
    end
`endif
  end

  assign last = finish;

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      counter <= '0;
      bitpos  <= '0;
      wordidx <= '0;
      bw_l    <= '0;
      msb_l   <= '0;
      nw_l    <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
`ifdef QUANTSER_PEND_EN
      pend_v  <= 1'b0;
      pbw_l   <= '0;
      pmsb_l  <= '0;
      pnw_l   <= '0;
`endif
    end else begin
      state <= state_n;
      done  <= finish;
      if (start && !ready) ovf <= 1'b1;
      if (load) begin
        counter <= bw_l;
        bitpos  <= msb_l;
      end
      if (step) begin
        counter <= counter - 1'b1;
        bitpos  <= bitpos - 1'b1;
      end
      if (adv_word) wordidx <= wordidx + 1'b1;
      if (take_new) begin
        bw_l    <= bwout;
        msb_l   <= msbidx;
        nw_l    <= nwords;
        wordidx <= '0;
      end
`ifdef QUANTSER_PEND_EN
      if (take_pend) begin
        bw_l    <= pbw_l;
        msb_l   <= pmsb_l;
        nw_l    <= pnw_l;
        wordidx <= '0;
        pend_v  <= 1'b0;
      end
      if (fill_pend) begin
        pbw_l  <= bwout;
        pmsb_l <= msbidx;
        pnw_l  <= nwords;
        pend_v <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_quantser_seqctrl.sv
// Directed table-driven bench for quantser_seqctrl; covers QUANTSER_PEND_EN when defined.
module tb_quantser_seqctrl;

  logic       clk = 1'b0;
  logic       clr, start, stall;
  logic [4:0] bwout, msbidx, bitpos;
  logic [3:0] nwords, wordidx;
  logic       ready, busy, load, step, last, done, ovf;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  quantser_seqctrl #(.BWOUT(32), .MAXBURST(16)) dut (
    .clk(clk), .clr(clr), .bwout(bwout), .msbidx(msbidx), .nwords(nwords),
    .start(start), .stall(stall), .ready(ready), .busy(busy), .load(load),
    .step(step), .bitpos(bitpos), .wordidx(wordidx), .last(last),
    .done(done), .ovf(ovf)
  );

  typedef struct {
    bit       clr, start, stall;
    int       bw, msb, nw;
    bit       ld, st, lst, dn, bsy, rdy, ov;
    int       bp, wi;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int row, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0d want=%0d", name, row, act, exp);
    end
  endtask

  task automatic add(input bit c, input bit s, input bit sl, input int bw, input int msb,
                     input int nw, input bit ld, input bit st, input bit lst, input bit dn,
                     input bit bsy, input bit rdy, input bit ov, input int bp, input int wi);
    vec_t v;
    v.clr = c; v.start = s; v.stall = sl; v.bw = bw; v.msb = msb; v.nw = nw;
    v.ld = ld; v.st = st; v.lst = lst; v.dn = dn; v.bsy = bsy; v.rdy = rdy;
    v.ov = ov; v.bp = bp; v.wi = wi;
    vq.push_back(v);
  endtask

  task automatic drive(input bit c, input bit s, input bit sl, input int bw, input int msb, input int nw);
    @(posedge clk);
    #1;
    clr = c; start = s; stall = sl;
    bwout = 5'(bw); msbidx = 5'(msb); nwords = 4'(nw);
    #3;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  int exp_ld [1:14];
  int exp_st [1:14];
  int n_ld, n_st, n_dn;

  initial begin
    clr = 1'b1; start = 1'b0; stall = 1'b0;
    bwout = '0; msbidx = '0; nwords = '0;

    //    clr st sl bw msb nw | ld st lst dn bsy rdy ov bp wi
    // single word: bwout=3 msbidx=7
    add(0,1,0, 3,7,0,  0,0,0,0,0,1,0,  0,0);
    add(0,0,0, 0,0,0,  1,0,0,0,1,0,0,  0,0);
    add(0,0,0, 0,0,0,  0,1,0,0,1,0,0,  7,0);
    add(0,0,0, 0,0,0,  0,1,0,0,1,0,0,  6,0);
    add(0,0,0, 0,0,0,  0,1,1,0,1,0,0,  5,0);
    add(0,0,0, 0,0,0,  0,0,0,1,0,1,0,  4,0);
    // bwout=0, four words: loads only
    add(0,1,0, 0,9,3,  0,0,0,0,0,1,0,  4,0);
    add(0,0,0, 0,0,0,  1,0,0,0,1,0,0,  4,0);
    add(0,0,0, 0,0,0,  1,0,0,0,1,0,0,  9,1);
    add(0,0,0, 0,0,0,  1,0,0,0,1,0,0,  9,2);
    add(0,0,0, 0,0,0,  1,0,1,0,1,0,0,  9,3);
    add(0,0,0, 0,0,0,  0,0,0,1,0,1,0,  9,3);
    // bitpos wrap: bwout=4 msbidx=1
    add(0,1,0, 4,1,0,  0,0,0,0,0,1,0,  9,3);
    add(0,0,0, 0,0,0,  1,0,0,0,1,0,0,  9,0);
    add(0,0,0, 0,0,0,  0,1,0,0,1,0,0,  1,0);
    add(0,0,0, 0,0,0,  0,1,0,0,1,0,0,  0,0);
    add(0,0,0, 0,0,0,  0,1,0,0,1,0,0, 31,0);
    add(0,0,0, 0,0,0,  0,1,1,0,1,0,0, 30,0);
    add(0,0,0, 0,0,0,  0,0,0,1,0,1,0, 29,0);
`ifdef QUANTSER_PEND_EN
    // queued second job chains with no idle gap; third start overruns
    add(0,1,0, 2,0,0,  0,0,0,0,0,1,0, 29,0);
    add(0,1,0, 1,5,0,  1,0,0,0,1,1,0, 29,0);
    add(0,1,0, 3,3,0,  0,1,0,0,1,0,0,  0,0);
    add(0,0,0, 0,0,0,  0,1,1,0,1,0,1, 31,0);
    add(0,0,0, 0,0,0,  1,0,0,1,1,1,1, 30,0);
    add(0,0,0, 0,0,0,  0,1,1,0,1,1,1,  5,0);
    add(0,0,0, 0,0,0,  0,0,0,1,0,1,1,  4,0);
    add(1,0,0, 0,0,0,  0,0,0,0,0,1,1,  4,0);
    add(0,0,0, 0,0,0,  0,0,0,0,0,1,0,  0,0);
`else
    // start while busy is dropped and sets sticky ovf; mid-job clr aborts
    add(0,1,0, 1,3,0,  0,0,0,0,0,1,0, 29,0);
    add(0,1,0, 5,5,5,  1,0,0,0,1,0,0, 29,0);
    add(0,0,0, 0,0,0,  0,1,1,0,1,0,1,  3,0);
    add(0,0,0, 0,0,0,  0,0,0,1,0,1,1,  2,0);
    add(0,1,0, 2,4,1,  0,0,0,0,0,1,1,  2,0);
    add(0,0,0, 0,0,0,  1,0,0,0,1,0,1,  2,0);
    add(0,0,0, 0,0,0,  0,1,0,0,1,0,1,  4,0);
    add(1,0,0, 0,0,0,  0,0,0,0,1,0,1,  3,0);
    add(0,0,0, 0,0,0,  0,0,0,0,0,1,0,  0,0);
    add(0,0,0, 0,0,0,  0,0,0,0,0,1,0,  0,0);
`endif

    do_reset();
    chk("rst_ready", -1, int'(ready), 1);
    chk("rst_busy",  -1, int'(busy),  0);
    chk("rst_ovf",   -1, int'(ovf),   0);
    chk("rst_done",  -1, int'(done),  0);

    foreach (vq[i]) begin
      drive(vq[i].clr, vq[i].start, vq[i].stall, vq[i].bw, vq[i].msb, vq[i].nw);
      chk("load",    i, int'(load),    int'(vq[i].ld));
      chk("step",    i, int'(step),    int'(vq[i].st));
      chk("last",    i, int'(last),    int'(vq[i].lst));
      chk("done",    i, int'(done),    int'(vq[i].dn));
      chk("busy",    i, int'(busy),    int'(vq[i].bsy));
      chk("ready",   i, int'(ready),   int'(vq[i].rdy));
      chk("ovf",     i, int'(ovf),     int'(vq[i].ov));
      chk("bitpos",  i, int'(bitpos),  vq[i].bp);
      chk("wordidx", i, int'(wordidx), vq[i].wi);
    end

    // burst of 3 words, bwout=2, stall on cycles 5-6 (first steps of word 1)
    for (int k = 1; k <= 14; k++) begin exp_ld[k] = 0; exp_st[k] = 0; end
    exp_ld[1] = 1; exp_ld[4] = 1; exp_ld[9] = 1;
    exp_st[2] = 1; exp_st[3] = 1; exp_st[7] = 1; exp_st[8] = 1;
    exp_st[10] = 1; exp_st[11] = 1;
    do_reset();
    drive(0, 1, 0, 2, 2, 2);
    n_ld = 0; n_st = 0; n_dn = 0;
    for (int k = 1; k <= 14; k++) begin
      drive(0, 0, (k == 5 || k == 6), 0, 0, 0);
      chk("burst_load", k, int'(load), exp_ld[k]);
      chk("burst_step", k, int'(step), exp_st[k]);
      chk("burst_done", k, int'(done), (k == 12) ? 1 : 0);
      if (k == 7)  chk("burst_wi1", k, int'(wordidx), 1);
      if (k == 10) chk("burst_wi2", k, int'(wordidx), 2);
      if (k == 11) chk("burst_last", k, int'(last), 1);
      n_ld += int'(load);
      n_st += int'(step);
      n_dn += int'(done);
    end
    chk("burst_nload", 0, n_ld, 3);
    chk("burst_nstep", 0, n_st, 6);
    chk("burst_ndone", 0, n_dn, 1);
    chk("burst_ovf",   0, int'(ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
